// File: rtl/pipe_mac_feeder_pkg.sv
// Shared types and default geometry for the MAC input feeder.
// Holds the feeder state encoding and the parameter defaults used by the top.
// Address widths are derived in the top from these depths with $clog2.
package pipe_mac_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

    localparam int DEF_IF_CELL_SIZE     = 8;
    localparam int DEF_FILTER_CELL_SIZE = 8;
    localparam int DEF_FILTER_SIZE      = 4;
    localparam int DEF_IF_DEPTH         = 16;
    localparam int DEF_FILTER_DEPTH     = 16;
    localparam int DEF_STRIDE           = 1;
    localparam int DEF_WIN_W            = 8;

endpackage

// File: rtl/pipe_mac_feeder_token_stage.sv
// One stage of the feeder token pipe: a valid bit plus a last-of-window marker.
// Latency: 1 cycle from i_vld/i_last to o_vld/o_last when not held.
// Backpressure: i_hold freezes the stage contents (downstream stall).
module pipe_mac_feeder_token_stage (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hold,
    input  logic i_vld,
    input  logic i_last,
    output logic o_vld,
    output logic o_last
);

    logic r_vld;
    logic r_last;

    // Capture the upstream token unless the pipe is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else if (!i_hold) begin
            r_vld  <= i_vld;
            r_last <= i_last;
        end
    end

    assign o_vld  = r_vld;
    assign o_last = r_last;

endmodule

// File: rtl/pipe_mac_feeder.sv
// Sequencer feeding IF/filter element pairs from the scratchpads into the pipelined MAC.
// Latency: last issue of a window -> o_psum_valid is 3 unstalled cycles; o_done one cycle after final sum.
// Backpressure: i_pipe_stall freezes counters, token pipe and loads; addresses hold the last issued pair.
module pipe_mac_feeder
    import pipe_mac_feeder_pkg::*;
#(
    parameter int IF_CELL_SIZE     = DEF_IF_CELL_SIZE,
    parameter int FILTER_CELL_SIZE = DEF_FILTER_CELL_SIZE,
    parameter int FILTER_SIZE      = DEF_FILTER_SIZE,
    parameter int IF_DEPTH         = DEF_IF_DEPTH,
    parameter int FILTER_DEPTH     = DEF_FILTER_DEPTH,
    parameter int STRIDE           = DEF_STRIDE,
    parameter int WIN_W            = DEF_WIN_W
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [WIN_W-1:0]                i_num_windows,
    input  logic [$clog2(IF_DEPTH)-1:0]     i_if_base,
    input  logic                            i_pipe_stall,
    output logic [$clog2(IF_DEPTH)-1:0]     o_if_raddr,
    output logic [$clog2(FILTER_DEPTH)-1:0] o_filter_raddr,
    input  logic [IF_CELL_SIZE-1:0]         i_if_rdata,
    input  logic [FILTER_CELL_SIZE-1:0]     i_filter_rdata,
    output logic [IF_CELL_SIZE-1:0]         o_if_out,
    output logic [FILTER_CELL_SIZE-1:0]     o_filter_out,
    output logic                            o_ld_mult,
    output logic                            o_ld_add,
    output logic                            o_par_done,
    output logic                            o_psum_valid,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int IF_AW = $clog2(IF_DEPTH);
    localparam int F_AW  = $clog2(FILTER_DEPTH);
    localparam logic [F_AW-1:0]  K_LAST = F_AW'(FILTER_SIZE - 1);
    localparam logic [IF_AW-1:0] STEP   = IF_AW'(STRIDE);

    feeder_state_t      r_state;
    logic [F_AW-1:0]    r_k;
    logic [WIN_W-1:0]   r_w;
    logic [WIN_W-1:0]   r_num_windows;
    logic [IF_AW-1:0]   r_base;
    logic [IF_AW-1:0]   r_hold_if_addr;
    logic [F_AW-1:0]    r_hold_f_addr;
    logic               r_psum_valid;
    logic               r_done;

    logic               w_issue;
    logic               w_k_last;
    logic               w_last_win;
    logic [IF_AW-1:0]   w_cur_if_addr;
    logic               w_v1;
    logic               w_last1;
    logic               w_v2;
    logic               w_last2;

    assign w_issue       = (r_state == ST_RUN) && !i_pipe_stall;
    assign w_k_last      = (r_k == K_LAST);
    assign w_last_win    = (r_w == (r_num_windows - WIN_W'(1)));
    assign w_cur_if_addr = r_base + IF_AW'(r_k);

    // While stalled the scratchpads keep re-reading the last issued pair, so the
    // rdata seen by a held v1 token stays the data that token asked for.
    assign o_if_raddr     = i_pipe_stall ? r_hold_if_addr : w_cur_if_addr;
    assign o_filter_raddr = i_pipe_stall ? r_hold_f_addr  : r_k;

    // Sequencer: launches runs, walks (k, window) address pairs, waits for the pipe to empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_k            <= '0;
            r_w            <= '0;
            r_num_windows  <= '0;
            r_base         <= '0;
            r_hold_if_addr <= '0;
            r_hold_f_addr  <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_k           <= '0;
                        r_w           <= '0;
                        r_base        <= i_if_base;
                        r_num_windows <= i_num_windows;
                        if (i_num_windows == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_hold_if_addr <= w_cur_if_addr;
                        r_hold_f_addr  <= r_k;
                        if (w_k_last) begin
                            r_k    <= '0;
                            r_base <= r_base + STEP;
                            r_w    <= r_w + WIN_W'(1);
                            if (w_last_win) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_k <= r_k + F_AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // The final psum pulse coincides with the last token leaving v2.
                    if (!w_v1 && !w_v2 && r_psum_valid) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1: pair data is on rdata (drives the mult register load).
    pipe_mac_feeder_token_stage u_stage1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_hold (i_pipe_stall),
        .i_vld  (w_issue),
        .i_last (w_k_last),
        .o_vld  (w_v1),
        .o_last (w_last1)
    );

    // Stage 2: product sits in the mult register (drives the accumulator load).
    pipe_mac_feeder_token_stage u_stage2 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_hold (i_pipe_stall),
        .i_vld  (w_v1),
        .i_last (w_last1),
        .o_vld  (w_v2),
        .o_last (w_last2)
    );

    // Flag the cycle after the window's last accumulate, when the MAC output holds the sum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_psum_valid <= 1'b0;
        end else begin
            r_psum_valid <= w_v2 && w_last2 && !i_pipe_stall;
        end
    end

    assign o_if_out     = i_if_rdata;
    assign o_filter_out = i_filter_rdata;
    assign o_ld_mult    = w_v1 && !i_pipe_stall;
    assign o_ld_add     = w_v2 && !i_pipe_stall;
    assign o_par_done   = w_v1 && w_last1 && !i_pipe_stall;
    assign o_psum_valid = r_psum_valid;
    assign o_busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done       = r_done;

endmodule

// File: tb/tb_pipe_mac_feeder.sv
module tb_pipe_mac_feeder;

    localparam int FS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stall;
    logic [7:0] num_windows;
    logic [3:0] if_base;
    logic [3:0] if_raddr;
    logic [3:0] filter_raddr;
    logic [7:0] if_rdata;
    logic [7:0] filter_rdata;
    logic [7:0] if_out;
    logic [7:0] filter_out;
    logic       ld_mult;
    logic       ld_add;
    logic       par_done;
    logic       psum_valid;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    pipe_mac_feeder dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_num_windows  (num_windows),
        .i_if_base      (if_base),
        .i_pipe_stall   (stall),
        .o_if_raddr     (if_raddr),
        .o_filter_raddr (filter_raddr),
        .i_if_rdata     (if_rdata),
        .i_filter_rdata (filter_rdata),
        .o_if_out       (if_out),
        .o_filter_out   (filter_out),
        .o_ld_mult      (ld_mult),
        .o_ld_add       (ld_add),
        .o_par_done     (par_done),
        .o_psum_valid   (psum_valid),
        .o_busy         (busy),
        .o_done         (done)
    );

    // Scratchpads with one-cycle synchronous read
    logic [7:0] if_mem [16];
    logic [7:0] f_mem  [16];

    always @(posedge clk) begin
        if_rdata     <= if_mem[if_raddr];
        filter_rdata <= f_mem[filter_raddr];
    end

    // Downstream MAC: mult register, accumulator that restarts after a marked last product
    logic [15:0] mreg;
    logic        mlast;
    logic [31:0] acc;
    logic        aclr;

    always @(posedge clk) begin
        if (rst) begin
            mreg  <= '0;
            mlast <= 1'b0;
            acc   <= '0;
            aclr  <= 1'b1;
        end else begin
            if (ld_mult) begin
                mreg  <= 16'(if_out) * 16'(filter_out);
                mlast <= par_done;
            end
            if (ld_add) begin
                acc  <= (aclr ? 32'd0 : acc) + 32'(mreg);
                aclr <= mlast;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    int n_ldm, n_pd, n_done, first_ldm, last_ldm, done_cyc;
    logic [31:0] sum_q[$];
    logic [31:0] psum_cyc_q[$];
    logic [31:0] addr_if_q[$];
    logic [31:0] addr_f_q[$];
    logic [31:0] trace_if[$];
    logic [31:0] trace_ldm[$];
    logic [3:0]  prev_if, prev_f;
    logic        s_ldm, s_ldadd, s_pd, s_psv, s_busy, s_done;
    logic [3:0]  s_ifa, s_fa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // One clock: sample outputs mid-cycle, then move to just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        s_ldm = ld_mult; s_ldadd = ld_add; s_pd = par_done; s_psv = psum_valid;
        s_busy = busy; s_done = done; s_ifa = if_raddr; s_fa = filter_raddr;
        if (ld_mult) begin
            n_ldm++;
            if (first_ldm < 0) first_ldm = cyc_n;
            last_ldm = cyc_n;
            addr_if_q.push_back(32'(prev_if));
            addr_f_q.push_back(32'(prev_f));
        end
        if (par_done) n_pd++;
        if (psum_valid) begin
            sum_q.push_back(acc);
            psum_cyc_q.push_back(32'(cyc_n));
        end
        if (done) begin
            n_done++;
            done_cyc = cyc_n;
        end
        trace_if.push_back(32'(if_raddr));
        trace_ldm.push_back(32'(ld_mult));
        prev_if = if_raddr;
        prev_f  = filter_raddr;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        n_ldm = 0; n_pd = 0; n_done = 0; first_ldm = -1; last_ldm = -1; done_cyc = -1;
        sum_q.delete(); psum_cyc_q.delete(); addr_if_q.delete(); addr_f_q.delete();
        trace_if.delete(); trace_ldm.delete();
    endtask

    // mode 0: no stall, 1: stall cycles s+2..s+4, 2: random stall
    task automatic run(input string tag, input int nw, input logic [3:0] base, input int mode,
                       output int s);
        int budget;
        int rel;
        clear_obs();
        num_windows = 8'(nw);
        if_base     = base;
        stall       = 1'b0;
        start       = 1'b1;
        cyc();
        s     = cyc_n;
        start = 1'b0;
        trace_if.delete();
        trace_ldm.delete();
        budget = 0;
        while (n_done == 0 && budget < 400) begin
            rel = cyc_n + 1 - s;
            case (mode)
                1:       stall = (rel >= 2 && rel <= 4);
                2:       stall = ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
            cyc();
            budget++;
        end
        stall = 1'b0;
        cyc();
        cyc();
        chk({tag, "_done_once"}, 32'(n_done), 32'd1);
    endtask

    // Reference: window w sums IF[(base + w*STRIDE + k) mod 16] * F[k] over k.
    task automatic check_run(input string tag, input int nw, input logic [3:0] base);
        int          idx;
        logic [31:0] exp_sum;
        int          a;
        chk({tag, "_ld_mult_count"}, 32'(n_ldm), 32'(nw * FS));
        chk({tag, "_par_done_count"}, 32'(n_pd), 32'(nw));
        chk({tag, "_psum_count"}, 32'(sum_q.size()), 32'(nw));
        idx = 0;
        for (int w = 0; w < nw; w++) begin
            exp_sum = 0;
            for (int k = 0; k < FS; k++) begin
                a = (int'(base) + w * 1 + k) % 16;
                exp_sum += 32'(if_mem[a]) * 32'(f_mem[k]);
                chk($sformatf("%s_pair%0d", tag, idx),
                    qget(addr_if_q, idx) * 16 + qget(addr_f_q, idx), 32'(a * 16 + k));
                idx++;
            end
            chk($sformatf("%s_sum%0d", tag, w), qget(sum_q, w), exp_sum);
        end
        if (nw > 0)
            chk({tag, "_done_after_psum"}, 32'(done_cyc), qget(psum_cyc_q, nw - 1) + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1; start = 1'b0; stall = 1'b0; num_windows = '0; if_base = '0;
        prev_if = '0; prev_f = '0;
        for (int i = 0; i < 16; i++) begin
            if_mem[i] = 8'(i + 1);
            f_mem[i]  = 8'd1;
        end
        clear_obs();
        cyc();
        cyc();
        // Reset state
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_done", 32'(s_done), 32'd0);
        chk("rst_loads", 32'({s_ldm, s_ldadd, s_pd, s_psv}), 32'd0);
        chk("rst_raddr", 32'({s_ifa, s_fa}), 32'd0);
        rst = 1'b0;
        cyc();

        // Single window, IF = 1..4, filter = 1
        run("one_win", 1, 4'd0, 0, s);
        check_run("one_win", 1, 4'd0);
        chk("one_win_mac10", qget(sum_q, 0), 32'd10);
        chk("one_win_first_ldm", 32'(first_ldm), 32'(s + 2));
        chk("one_win_psum_cyc", qget(psum_cyc_q, 0), 32'(s + 7));
        chk("one_win_done_cyc", 32'(done_cyc), 32'(s + 8));
        chk("one_win_idle_busy", 32'(s_busy), 32'd0);

        // Three back-to-back windows over IF = 0..15
        for (int i = 0; i < 16; i++) if_mem[i] = 8'(i);
        run("b2b", 3, 4'd0, 0, s);
        check_run("b2b", 3, 4'd0);
        chk("b2b_sum0", qget(sum_q, 0), 32'd6);
        chk("b2b_sum1", qget(sum_q, 1), 32'd10);
        chk("b2b_sum2", qget(sum_q, 2), 32'd14);
        chk("b2b_ldm_span", 32'(last_ldm - first_ldm), 32'd11);
        chk("b2b_psum1_cyc", qget(psum_cyc_q, 1), 32'(s + 11));
        chk("b2b_psum2_cyc", qget(psum_cyc_q, 2), 32'(s + 15));

        // Three-cycle stall inside the window
        for (int i = 0; i < 16; i++) if_mem[i] = 8'(i + 1);
        run("stall", 1, 4'd0, 1, s);
        check_run("stall", 1, 4'd0);
        chk("stall_sum", qget(sum_q, 0), 32'd10);
        chk("stall_psum_cyc", qget(psum_cyc_q, 0), 32'(s + 10));
        for (int j = 2; j <= 4; j++) begin
            chk($sformatf("stall_addr_frozen%0d", j), qget(trace_if, j - 1), 32'd0);
            chk($sformatf("stall_no_ldm%0d", j), qget(trace_ldm, j - 1), 32'd0);
        end
        chk("stall_resume_addr", qget(trace_if, 4), 32'd1);
        chk("stall_resume_ldm", qget(trace_ldm, 4), 32'd1);

        // Address wrap from base 14
        run("wrap", 1, 4'd14, 0, s);
        check_run("wrap", 1, 4'd14);
        chk("wrap_a0", qget(trace_if, 0), 32'd14);
        chk("wrap_a1", qget(trace_if, 1), 32'd15);
        chk("wrap_a2", qget(trace_if, 2), 32'd0);
        chk("wrap_a3", qget(trace_if, 3), 32'd1);

        // Zero windows
        run("zero", 0, 4'd3, 0, s);
        chk("zero_done_cyc", 32'(done_cyc), 32'(s + 1));
        chk("zero_no_ldm", 32'(n_ldm), 32'd0);
        chk("zero_no_psum", 32'(sum_q.size()), 32'd0);

        // Reset in the middle of a run
        clear_obs();
        num_windows = 8'd3; if_base = 4'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_busy", 32'(s_busy), 32'd0);
        chk("midrst_loads", 32'({s_ldm, s_ldadd, s_pd, s_psv, s_done}), 32'd0);
        chk("midrst_raddr", 32'({s_ifa, s_fa}), 32'd0);
        for (int i = 0; i < 6; i++) cyc();
        chk("midrst_no_done", 32'(n_done), 32'd0);
        chk("midrst_no_psum", 32'(sum_q.size()), 32'd0);
        run("after_rst", 2, 4'd5, 0, s);
        check_run("after_rst", 2, 4'd5);

        // Randomized data, bases, window counts and stalls
        for (int it = 0; it < 6; it++) begin
            int          nw;
            logic [3:0]  base;
            for (int i = 0; i < 16; i++) begin
                if_mem[i] = 8'($urandom_range(0, 255));
                f_mem[i]  = 8'($urandom_range(0, 255));
            end
            nw   = int'($urandom_range(1, 5));
            base = 4'($urandom_range(0, 15));
            run($sformatf("rnd%0d", it), nw, base, 2, s);
            check_run($sformatf("rnd%0d", it), nw, base);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
